// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle control unit for the 16-bit ALU: fetch, decode, execute, memory, writeback.
// Optional build macro ILLEGAL_TRAP_EN: R-type funct 7 halts the core instead of acting as a NOP.
module alu_ctrl_fsm #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  output logic          instr_req,
  input  logic          instr_valid,
  input  logic [DW-1:0] instr_data,
  output logic [DW-1:0] pc,
  output logic [4:0]    alu_control,
  output logic          alu_src,
  output logic [DW-1:0] imm_out,
  output logic [2:0]    rs1_addr,
  output logic [2:0]    rs2_addr,
  output logic [2:0]    rd_addr,
  input  logic          branch_gate,
  input  logic [DW-1:0] alu_result,
  output logic          mem_read,
  output logic          mem_write,
  input  logic          mem_ack,
  output logic          reg_write,
  output logic [1:0]    wb_sel,
  output logic          halted
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]    state_reg, state_next;
  logic [DW-1:0] pc_reg, pc_next;
  logic [DW-1:0] instr_reg, instr_next;
  logic [DW-1:0] target_reg, target_next;

  logic [3:0]    op;
  logic [2:0]    funct;
  logic [DW-1:0] imm_sext, imm_zext;

  logic [4:0]    dec_ctrl;
  logic          dec_src;
  logic [DW-1:0] dec_imm;
  logic [2:0]    dec_rd, dec_rs1, dec_rs2;
  logic [1:0]    dec_wbsel;
  logic          is_alu, is_load, is_store, is_branch, is_jalr, is_halt, is_illegal;
  logic          active;

  assign op    = instr_reg[15:12];
  assign funct = instr_reg[2:0];

  assign imm_sext[5:0] = instr_reg[5:0];
  assign imm_zext[5:0] = instr_reg[5:0];
  genvar gi;
  generate
    for (gi = 6; gi < DW; gi++) begin : g_imm_ext
      assign imm_sext[gi] = instr_reg[5];
      assign imm_zext[gi] = 1'b0;
    end
  endgenerate

  // Decode is purely a function of the latched instruction, so fields stay stable until the next fetch.
  always_comb begin
    dec_ctrl   = 5'd0;
    dec_src    = 1'b0;
    dec_imm    = '0;
    dec_rd     = 3'd0;
    dec_rs1    = 3'd0;
    dec_rs2    = 3'd0;
    dec_wbsel  = 2'b00;
    is_alu     = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_jalr    = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (op)
      4'd0: begin
        dec_rd  = instr_reg[11:9];
        dec_rs1 = instr_reg[8:6];
        dec_rs2 = instr_reg[5:3];
        if (funct != 3'd7) begin
          dec_ctrl = {2'b00, funct} + 5'd1;
          is_alu   = 1'b1;
        end else begin
          is_illegal = 1'b1;
        end
      end
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
        dec_ctrl = {1'b0, op} + 5'd7;
        dec_src  = 1'b1;
        dec_imm  = (op == 4'd1) ? imm_sext : imm_zext;
        dec_rd   = instr_reg[11:9];
        dec_rs1  = instr_reg[8:6];
        is_alu   = 1'b1;
      end
      4'd7: begin
        dec_ctrl  = 5'd14;
        dec_src   = 1'b1;
        dec_imm   = imm_sext;
        dec_rd    = instr_reg[11:9];
        dec_rs1   = instr_reg[8:6];
        dec_wbsel = 2'b01;
        is_load   = 1'b1;
      end
      4'd8: begin
        dec_ctrl = 5'd15;
        dec_src  = 1'b1;
        dec_imm  = imm_sext;
        dec_rs1  = instr_reg[11:9];
        dec_rs2  = instr_reg[8:6];
        is_store = 1'b1;
      end
      4'd9, 4'd10, 4'd11, 4'd12: begin
        dec_ctrl  = {1'b0, op} + 5'd7;
        dec_imm   = imm_sext;
        dec_rs1   = instr_reg[11:9];
        dec_rs2   = instr_reg[8:6];
        is_branch = 1'b1;
      end
      4'd13: begin
        dec_ctrl  = 5'd20;
        dec_src   = 1'b1;
        dec_imm   = imm_sext;
        dec_rd    = instr_reg[11:9];
        dec_rs1   = instr_reg[8:6];
        dec_wbsel = 2'b10;
        is_jalr   = 1'b1;
      end
      4'd15: is_halt = 1'b1;
      default: ;
    endcase
  end

  // JALR target is captured in EXEC and applied in WB so pc still holds the
  // JALR address while the link value pc+1 is being written back.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    instr_next  = instr_reg;
    target_next = target_reg;
    case (state_reg)
      S_FETCH: begin
        if (instr_valid) begin
          instr_next = instr_data;
          state_next = S_DECODE;
        end
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if (is_alu) begin
          state_next = S_WB;
        end else if (is_load || is_store) begin
          state_next = S_MEM;
        end else if (is_branch) begin
          pc_next    = branch_gate ? (pc_reg + dec_imm) : (pc_reg + 1'b1);
          state_next = S_FETCH;
        end else if (is_jalr) begin
          target_next = alu_result;
          state_next  = S_WB;
        end else if (is_halt) begin
          state_next = S_HALT;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          if (is_illegal) begin
            state_next = S_HALT;
          end else begin
            pc_next    = pc_reg + 1'b1;
            state_next = S_FETCH;
          end
`else
          pc_next    = pc_reg + 1'b1;
          state_next = S_FETCH;
`endif
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          if (is_load) begin
            state_next = S_WB;
          end else begin
            pc_next    = pc_reg + 1'b1;
            state_next = S_FETCH;
          end
        end
      end
      S_WB: begin
        pc_next    = is_jalr ? target_reg : (pc_reg + 1'b1);
        state_next = S_FETCH;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_FETCH;
      pc_reg     <= RESET_PC;
      instr_reg  <= '0;
      target_reg <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      instr_reg  <= instr_next;
      target_reg <= target_next;
    end
  end

  assign active      = (state_reg == S_DECODE) || (state_reg == S_EXEC) ||
                       (state_reg == S_MEM)    || (state_reg == S_WB);
  assign instr_req   = (state_reg == S_FETCH);
  assign pc          = pc_reg;
  assign alu_control = active ? dec_ctrl : 5'd0;
  assign alu_src     = active ? dec_src : 1'b0;
  assign imm_out     = dec_imm;
  assign rs1_addr    = dec_rs1;
  assign rs2_addr    = dec_rs2;
  assign rd_addr     = dec_rd;
  assign mem_read    = (state_reg == S_MEM) && is_load;
  assign mem_write   = (state_reg == S_MEM) && is_store;
  assign reg_write   = (state_reg == S_WB);
  assign wb_sel      = dec_wbsel;
  assign halted      = (state_reg == S_HALT);

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed bench for alu_ctrl_fsm: reset, ALU/immediate decode, branches, JALR, memory, wrap, trap/halt.
module tb_alu_ctrl_fsm;
  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [15:0] pc;
  logic [4:0]  alu_control;
  logic        alu_src;
  logic [15:0] imm_out;
  logic [2:0]  rs1_addr, rs2_addr, rd_addr;
  logic        branch_gate;
  logic [15:0] alu_result;
  logic        mem_read, mem_write, mem_ack;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        halted;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_ctrl_fsm #(.RESET_PC(16'h0000), .DW(16)) dut (
    .clk(clk), .reset(reset), .instr_req(instr_req), .instr_valid(instr_valid),
    .instr_data(instr_data), .pc(pc), .alu_control(alu_control), .alu_src(alu_src),
    .imm_out(imm_out), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .branch_gate(branch_gate), .alu_result(alu_result), .mem_read(mem_read),
    .mem_write(mem_write), .mem_ack(mem_ack), .reg_write(reg_write), .wb_sel(wb_sel),
    .halted(halted)
  );

  // Waits for the fetch request, optionally stalls, then presents ins for one cycle.
  // Returns at the falling edge of the DECODE cycle.
  task automatic do_fetch(input logic [15:0] ins, input int waits);
    int guard = 0;
    while (instr_req !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (instr_req !== 1'b1) begin
      fails++;
      $display("FAIL fetch_timeout: instr_req=%b required 1", instr_req);
    end
    for (int i = 0; i < waits; i++) @(negedge clk);
    $display("[TB] fetch instr=%h pc=%h waits=%0d", ins, pc, waits);
    instr_valid = 1'b1;
    instr_data  = ins;
    @(negedge clk);
    instr_valid = 1'b0;
    instr_data  = 16'h0000;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (pc !== 16'h0000) begin fails++; $display("FAIL reset_pc: got %h required 0000", pc); end
    tests++; if (instr_req !== 1'b1) begin fails++; $display("FAIL reset_req: got %b required 1", instr_req); end
    tests++; if (alu_control !== 5'd0 || alu_src !== 1'b0 || imm_out !== 16'h0) begin
      fails++; $display("FAIL reset_dec: ctrl=%0d src=%b imm=%h required 0/0/0000", alu_control, alu_src, imm_out); end
    tests++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || reg_write !== 1'b0 || wb_sel !== 2'b00 || halted !== 1'b0) begin
      fails++; $display("FAIL reset_strobes: rd=%b wr=%b rw=%b wb=%b h=%b required all 0", mem_read, mem_write, reg_write, wb_sel, halted); end
    reset = 1'b0;
    @(negedge clk);
    $display("[TB] reset done pc=%h", pc);
  endtask

  task automatic test_alu;
    do_fetch(16'h0A88, 0);
    tests++; if (alu_control !== 5'd1 || alu_src !== 1'b0) begin
      fails++; $display("FAIL add_decode: ctrl=%0d src=%b required 1/0", alu_control, alu_src); end
    tests++; if (rd_addr !== 3'd5 || rs1_addr !== 3'd2 || rs2_addr !== 3'd1) begin
      fails++; $display("FAIL add_regs: rd=%0d rs1=%0d rs2=%0d required 5/2/1", rd_addr, rs1_addr, rs2_addr); end
    @(negedge clk);
    tests++; if (reg_write !== 1'b0) begin fails++; $display("FAIL add_exec_rw: got %b required 0", reg_write); end
    @(negedge clk);
    tests++; if (reg_write !== 1'b1 || wb_sel !== 2'b00) begin
      fails++; $display("FAIL add_wb: rw=%b wb=%b required 1/00", reg_write, wb_sel); end
    @(negedge clk);
    tests++; if (pc !== 16'h0001 || reg_write !== 1'b0 || alu_control !== 5'd0 || instr_req !== 1'b1) begin
      fails++; $display("FAIL add_done: pc=%h rw=%b ctrl=%0d req=%b required 0001/0/0/1", pc, reg_write, alu_control, instr_req); end
  endtask

  task automatic test_imm;
    do_fetch(16'h103E, 2);
    tests++; if (imm_out !== 16'hFFFE || alu_control !== 5'd8 || alu_src !== 1'b1) begin
      fails++; $display("FAIL addi: imm=%h ctrl=%0d src=%b required FFFE/8/1", imm_out, alu_control, alu_src); end
    repeat (3) @(negedge clk);
    tests++; if (pc !== 16'h0002) begin fails++; $display("FAIL addi_pc: got %h required 0002", pc); end
    do_fetch(16'h203E, 0);
    tests++; if (imm_out !== 16'h003E || alu_control !== 5'd9) begin
      fails++; $display("FAIL andi: imm=%h ctrl=%0d required 003E/9", imm_out, alu_control); end
    repeat (3) @(negedge clk);
    tests++; if (pc !== 16'h0003) begin fails++; $display("FAIL andi_pc: got %h required 0003", pc); end
  endtask

  task automatic test_branch;
    do_fetch(16'hD000, 0);
    tests++; if (alu_control !== 5'd20 || alu_src !== 1'b1) begin
      fails++; $display("FAIL jalr_decode: ctrl=%0d src=%b required 20/1", alu_control, alu_src); end
    alu_result = 16'h0010;
    @(negedge clk);
    @(negedge clk);
    tests++; if (reg_write !== 1'b1 || wb_sel !== 2'b10 || pc !== 16'h0003) begin
      fails++; $display("FAIL jalr_wb: rw=%b wb=%b pc=%h required 1/10/0003", reg_write, wb_sel, pc); end
    @(negedge clk);
    alu_result = 16'h0000;
    tests++; if (pc !== 16'h0010) begin fails++; $display("FAIL jalr_pc: got %h required 0010", pc); end

    do_fetch(16'h9004, 0);
    tests++; if (alu_control !== 5'd16 || alu_src !== 1'b0 || imm_out !== 16'h0004) begin
      fails++; $display("FAIL beq_decode: ctrl=%0d src=%b imm=%h required 16/0/0004", alu_control, alu_src, imm_out); end
    branch_gate = 1'b1;
    @(negedge clk);
    tests++; if (reg_write !== 1'b0) begin fails++; $display("FAIL beq_rw: got %b required 0", reg_write); end
    @(negedge clk);
    branch_gate = 1'b0;
    tests++; if (pc !== 16'h0014 || instr_req !== 1'b1) begin
      fails++; $display("FAIL beq_taken: pc=%h req=%b required 0014/1", pc, instr_req); end

    do_fetch(16'hD000, 0);
    alu_result = 16'h0010;
    repeat (3) @(negedge clk);
    alu_result = 16'h0000;
    do_fetch(16'h9004, 0);
    branch_gate = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (pc !== 16'h0011) begin fails++; $display("FAIL beq_not_taken: pc=%h required 0011", pc); end

    do_fetch(16'hC03F, 0);
    tests++; if (alu_control !== 5'd19 || imm_out !== 16'hFFFF) begin
      fails++; $display("FAIL blt_decode: ctrl=%0d imm=%h required 19/FFFF", alu_control, imm_out); end
    branch_gate = 1'b1;
    repeat (2) @(negedge clk);
    branch_gate = 1'b0;
    tests++; if (pc !== 16'h0010) begin fails++; $display("FAIL blt_back: pc=%h required 0010", pc); end
  endtask

  task automatic test_load;
    do_fetch(16'h7283, 0);
    tests++; if (alu_control !== 5'd14 || alu_src !== 1'b1 || imm_out !== 16'h0003 || rd_addr !== 3'd1 || rs1_addr !== 3'd2) begin
      fails++; $display("FAIL load_decode: ctrl=%0d src=%b imm=%h rd=%0d rs1=%0d required 14/1/0003/1/2",
                        alu_control, alu_src, imm_out, rd_addr, rs1_addr); end
    @(negedge clk);
    tests++; if (mem_read !== 1'b0) begin fails++; $display("FAIL load_exec_rd: got %b required 0", mem_read); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (mem_read !== 1'b1 || wb_sel !== 2'b01 || reg_write !== 1'b0) begin
        fails++; $display("FAIL load_mem%0d: rd=%b wb=%b rw=%b required 1/01/0", i, mem_read, wb_sel, reg_write); end
      if (i == 2) mem_ack = 1'b1;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    tests++; if (mem_read !== 1'b0 || reg_write !== 1'b1 || wb_sel !== 2'b01) begin
      fails++; $display("FAIL load_wb: rd=%b rw=%b wb=%b required 0/1/01", mem_read, reg_write, wb_sel); end
    @(negedge clk);
    tests++; if (pc !== 16'h0011 || reg_write !== 1'b0) begin
      fails++; $display("FAIL load_done: pc=%h rw=%b required 0011/0", pc, reg_write); end
  endtask

  task automatic test_store_reset;
    do_fetch(16'h8283, 0);
    tests++; if (alu_control !== 5'd15 || rs1_addr !== 3'd1 || rs2_addr !== 3'd2) begin
      fails++; $display("FAIL store_decode: ctrl=%0d rs1=%0d rs2=%0d required 15/1/2", alu_control, rs1_addr, rs2_addr); end
    repeat (2) @(negedge clk);
    tests++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin
      fails++; $display("FAIL store_mem: wr=%b rd=%b required 1/0", mem_write, mem_read); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++; if (mem_write !== 1'b0 || pc !== 16'h0000 || instr_req !== 1'b1 || alu_control !== 5'd0 || imm_out !== 16'h0) begin
      fails++; $display("FAIL store_reset: wr=%b pc=%h req=%b ctrl=%0d imm=%h required 0/0000/1/0/0000",
                        mem_write, pc, instr_req, alu_control, imm_out); end
  endtask

  task automatic test_wrap;
    do_fetch(16'hD000, 0);
    alu_result = 16'hFFFF;
    repeat (3) @(negedge clk);
    alu_result = 16'h0000;
    tests++; if (pc !== 16'hFFFF) begin fails++; $display("FAIL wrap_setup: pc=%h required FFFF", pc); end
    do_fetch(16'hE000, 0);
    tests++; if (alu_control !== 5'd0) begin fails++; $display("FAIL nop_decode: ctrl=%0d required 0", alu_control); end
    repeat (2) @(negedge clk);
    tests++; if (pc !== 16'h0000 || instr_req !== 1'b1) begin
      fails++; $display("FAIL wrap_pc: pc=%h req=%b required 0000/1", pc, instr_req); end
  endtask

  task automatic test_illegal;
    do_fetch(16'h0007, 0);
    tests++; if (alu_control !== 5'd0) begin fails++; $display("FAIL illegal_decode: ctrl=%0d required 0", alu_control); end
    @(negedge clk);
    tests++; if (reg_write !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      fails++; $display("FAIL illegal_side: rw=%b rd=%b wr=%b required 0/0/0", reg_write, mem_read, mem_write); end
    @(negedge clk);
`ifdef ILLEGAL_TRAP_EN
    tests++; if (halted !== 1'b1 || instr_req !== 1'b0 || reg_write !== 1'b0) begin
      fails++; $display("FAIL illegal_trap: h=%b req=%b rw=%b required 1/0/0", halted, instr_req, reg_write); end
`else
    tests++; if (halted !== 1'b0 || pc !== 16'h0001 || instr_req !== 1'b1 || reg_write !== 1'b0) begin
      fails++; $display("FAIL illegal_nop: h=%b pc=%h req=%b rw=%b required 0/0001/1/0", halted, pc, instr_req, reg_write); end
`endif
    $display("[TB] illegal funct7 done pc=%h halted=%b", pc, halted);
  endtask

  task automatic test_halt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    do_fetch(16'hF000, 0);
    repeat (2) @(negedge clk);
    tests++; if (halted !== 1'b1 || instr_req !== 1'b0 || alu_control !== 5'd0) begin
      fails++; $display("FAIL halt_enter: h=%b req=%b ctrl=%0d required 1/0/0", halted, instr_req, alu_control); end
    instr_valid = 1'b1;
    instr_data  = 16'h0A88;
    mem_ack     = 1'b1;
    repeat (3) @(negedge clk);
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    tests++; if (halted !== 1'b1 || instr_req !== 1'b0 || pc !== 16'h0000 || reg_write !== 1'b0) begin
      fails++; $display("FAIL halt_stay: h=%b req=%b pc=%h rw=%b required 1/0/0000/0", halted, instr_req, pc, reg_write); end
    $display("[TB] halt done halted=%b", halted);
  endtask

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr_data  = 16'h0000;
    branch_gate = 1'b0;
    alu_result  = 16'h0000;
    mem_ack     = 1'b0;
    @(negedge clk);
    test_reset();
    test_alu();
    test_imm();
    test_branch();
    test_load();
    test_store_reset();
    test_wrap();
    test_illegal();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
